// File: rtl/leglite_pkg.sv
// leglite_pkg: opcode constants, fetch FSM states and default widths shared by LEGLite blocks.
package leglite_pkg;
  localparam int DEF_PC_WIDTH    = 16;
  localparam int DEF_INSTR_WIDTH = 16;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } fetch_state_t;
endpackage

// File: rtl/leglite_next_pc.sv
// leglite_next_pc: sequential successor or PC-relative branch target (offset counted in instructions).
module leglite_next_pc #(
  parameter int PC_WIDTH  = 16,
  parameter int OFS_WIDTH = 12
) (
  input  logic [PC_WIDTH-1:0]  instr_pc_i,
  input  logic                 take_branch_i,
  input  logic [OFS_WIDTH-1:0] branch_offset_i,
  output logic [PC_WIDTH-1:0]  next_pc_o
);
  logic [PC_WIDTH-1:0] ofs_ext;
  assign ofs_ext   = PC_WIDTH'($signed(branch_offset_i));
  assign next_pc_o = take_branch_i ? instr_pc_i + (ofs_ext << 1) : instr_pc_i + PC_WIDTH'(2);
endmodule

// File: rtl/leglite_fetch.sv
// leglite_fetch: LEGLite fetch stage; one outstanding imem request, instruction register,
// next-PC selection, redirect with response draining, and HALT stop.
module leglite_fetch
  import leglite_pkg::*;
#(
  parameter int                 PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                 INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int                 OFS_WIDTH   = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [3:0]             opcode,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_accept,
  input  logic                   take_branch,
  input  logic [OFS_WIDTH-1:0]   branch_offset,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   halted,
  output logic [15:0]            retire_count
);
  fetch_state_t state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, instr_pc_q, instr_pc_d, next_pc;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [15:0]            retire_q, retire_d;
  logic                   owed;

  leglite_next_pc #(.PC_WIDTH(PC_WIDTH), .OFS_WIDTH(OFS_WIDTH)) u_next_pc (
    .instr_pc_i      (instr_pc_q),
    .take_branch_i   (take_branch),
    .branch_offset_i (branch_offset),
    .next_pc_o       (next_pc)
  );

  // A response is still owed if a request is in flight and not arriving this cycle.
  assign owed = (state_q == S_REQ) || (state_q == S_DRAIN) || (state_q == S_WAIT && !imem_rvalid);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retire_d   = retire_q;
    if (redirect) begin
      pc_d    = redirect_pc & ~PC_WIDTH'(1);
      state_d = owed ? S_DRAIN : S_REQ;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  state_d = S_WAIT;
        S_WAIT: if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
        S_HOLD: if (instr_accept) begin
          pc_d     = next_pc;
          retire_d = retire_q + 16'd1;
          state_d  = (opcode == OP_HALT) ? S_HALT : S_REQ;
        end
        S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retire_q   <= retire_d;
    end
  end

  assign imem_req     = state_q == S_REQ;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign opcode       = instr_q[INSTR_WIDTH-1 -: 4];
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = state_q == S_HOLD;
  assign halted       = state_q == S_HALT;
  assign retire_count = retire_q;
endmodule

// File: tb/tb_leglite_fetch.sv
// tb_leglite_fetch: directed checks of leglite_fetch against a simple variable-latency memory.
module tb_leglite_fetch;
  logic        clock = 0, reset_n = 0;
  logic        imem_req, imem_rvalid, instr_valid, instr_accept, take_branch, redirect, halted;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc, retire_count;
  logic [3:0]  opcode;
  logic [11:0] branch_offset;
  logic [15:0] mem_data = 16'h0123, exp_rc = 0;
  int          mem_lat = 1, cnt = 0, n_chk = 0, n_pass = 0;
  logic        pend;

  leglite_fetch dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_accept(instr_accept),
    .take_branch(take_branch), .branch_offset(branch_offset), .redirect(redirect),
    .redirect_pc(redirect_pc), .halted(halted), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 0;
      cnt <= 0;
      imem_rvalid <= 0;
      imem_rdata <= '0;
    end else begin
      imem_rvalid <= 0;
      if (imem_req) begin
        if (mem_lat <= 1) begin
          imem_rvalid <= 1;
          imem_rdata <= mem_data;
        end else begin
          pend <= 1;
          cnt <= mem_lat - 1;
        end
      end else if (pend) begin
        if (cnt <= 1) begin
          pend <= 0;
          imem_rvalid <= 1;
          imem_rdata <= mem_data;
        end else cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 50) begin
      tick();
      n++;
    end
    chk("valid_timeout", instr_valid, 1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    chk("req_timeout", imem_req, 1);
  endtask

  task automatic do_accept(input logic br, input logic [11:0] ofs);
    instr_accept = 1;
    take_branch = br;
    branch_offset = ofs;
    tick();
    instr_accept = 0;
    take_branch = 0;
    branch_offset = '0;
    exp_rc++;
  endtask

  task automatic do_redirect(input logic [15:0] a);
    redirect = 1;
    redirect_pc = a;
    tick();
    redirect = 0;
  endtask

  task automatic br_case(input logic br, input logic [11:0] ofs, input logic [15:0] exp);
    do_redirect(16'h0010);
    wait_valid();
    chk("br_ipc", instr_pc, 16'h0010);
    do_accept(br, ofs);
    chk("br_req", imem_req, 1);
    chk("br_addr", imem_addr, exp);
  endtask

  task automatic chk_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rc", retire_count, 0);
  endtask

  initial begin
    int seen;
    instr_accept = 0; take_branch = 0; branch_offset = '0; redirect = 0; redirect_pc = '0;
    tick(); tick();
    chk_reset();
    // 1: first fetch after reset
    reset_n = 1;
    tick();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 16'h0000);
    instr_accept = 1;
    tick();
    instr_accept = 0;
    wait_valid();
    chk("t1_instr", instr, 16'h0123);
    chk("t1_opcode", opcode, 4'h0);
    chk("t1_rc_idle_accept", retire_count, 0);
    do_accept(0, '0);
    chk("t1_addr2", imem_addr, 16'h0002);
    chk("t1_rc", retire_count, exp_rc);
    // 2: branch targets
    mem_data = 16'h5ABC;
    br_case(1, 12'hFFC, 16'h0008);
    chk("t2_opcode", opcode, 4'h5);
    br_case(1, 12'h003, 16'h0016);
    br_case(0, 12'h7FF, 16'h0012);
    // 3: redirect while waiting; late response must be dropped
    mem_lat = 3;
    do_redirect(16'h0004);
    wait_req();
    chk("t3_addr", imem_addr, 16'h0004);
    mem_data = 16'hAAAA;
    tick();
    do_redirect(16'h0100);
    seen = 0;
    for (int i = 0; i < 20 && !imem_req; i++) begin
      if (instr_valid) seen = 1;
      tick();
    end
    chk("t3_no_valid", seen, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr2", imem_addr, 16'h0100);
    mem_data = 16'h1111;
    mem_lat = 1;
    wait_valid();
    chk("t3_instr", instr, 16'h1111);
    chk("t3_ipc", instr_pc, 16'h0100);
    // 4: redirect beats accept in the same cycle
    redirect = 1;
    redirect_pc = 16'h0041;
    instr_accept = 1;
    take_branch = 1;
    branch_offset = 12'h010;
    tick();
    redirect = 0; instr_accept = 0; take_branch = 0; branch_offset = '0;
    chk("t4_valid", instr_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 16'h0040);
    chk("t4_rc", retire_count, exp_rc);
    // 5: HALT stops fetch until redirect
    mem_data = 16'hF000;
    wait_valid();
    chk("t5_opcode", opcode, 4'hF);
    do_accept(0, '0);
    chk("t5_halted", halted, 1);
    chk("t5_rc", retire_count, exp_rc);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) seen++;
      tick();
    end
    chk("t5_no_req", seen, 0);
    chk("t5_still_halted", halted, 1);
    do_redirect(16'h0040);
    chk("t5_unhalt", halted, 0);
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 16'h0040);
    // 6: PC wrap, then async reset mid-WAIT
    mem_data = 16'h0123;
    do_redirect(16'hFFFE);
    wait_valid();
    chk("t6_ipc", instr_pc, 16'hFFFE);
    do_accept(0, '0);
    chk("t6_req", imem_req, 1);
    chk("t6_wrap", imem_addr, 16'h0000);
    chk("t6_rc", retire_count, exp_rc);
    mem_lat = 3;
    tick();
    reset_n = 0;
    #1;
    chk_reset();
    tick();
    mem_lat = 1;
    reset_n = 1;
    tick();
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
